mem_responder: RTL and testbench

- Word-addressed program/data memory answering the CPU controller's memory strobes (rd_mem, wr_mem) on the shared address bus and data bus.
- Reads are combinational, so that fetch and lda complete in the same cycle the strobe is asserted. Writes commit on the clock edge.
- Contains a host loader FSM that streams a program into memory through a valid/ready handshake. Loading happens only while the CPU is parked in its idle state, and the block holds off further stepping until the load completes.

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/host side and mem_responder: CPU memory strobes,
// shared address/data buses, and the host program-loader handshake.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  rd_mem;
  logic                  wr_mem;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  cpu_idle;
  logic                  hold;
  logic                  ld_start;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  ld_busy;
  logic                  ld_done;
  logic [ADDR_WIDTH:0]   ld_count;
  logic                  err;

  modport master (
    output rd_mem, wr_mem, adr, data_in, cpu_idle,
           ld_start, ld_valid, ld_data, ld_last,
    input  data_out, hold, ld_ready, ld_busy, ld_done, ld_count, err
  );

  modport slave (
    input  rd_mem, wr_mem, adr, data_in, cpu_idle,
           ld_start, ld_valid, ld_data, ld_last,
    output data_out, hold, ld_ready, ld_busy, ld_done, ld_count, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed program/data memory for the CPU, with combinational reads,
// clocked writes and a host loader FSM that streams a program in from address 0.
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ARM, LOAD, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  err_q;

  logic cpu_side;
  logic cpu_write;
  logic load_accept;
  logic load_end;
  logic err_set;

  // The CPU owns the memory only while no load is pending or in progress.
  assign cpu_side    = (state == IDLE) || (state == DONE);
  assign cpu_write   = cpu_side && bus.wr_mem;
  assign load_accept = (state == LOAD) && bus.ld_valid;
  assign load_end    = load_accept && (bus.ld_last || (ptr == '1));
  assign err_set     = (bus.rd_mem && bus.wr_mem) ||
                       ((state == LOAD) && (bus.rd_mem || bus.wr_mem));

  assign bus.data_out = (cpu_side && bus.rd_mem && !bus.wr_mem) ? mem[bus.adr] : '0;
  assign bus.ld_count = count;
  assign bus.err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.ld_start) state_next = ARM;
      ARM:  if (bus.cpu_idle) state_next = LOAD;
      LOAD: if (load_end)     state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.hold     = 1'b0;
    bus.ld_busy  = 1'b0;
    bus.ld_ready = 1'b0;
    bus.ld_done  = 1'b0;
    unique case (state)
      ARM: begin
        bus.hold    = 1'b1;
        bus.ld_busy = 1'b1;
      end
      LOAD: begin
        bus.hold     = 1'b1;
        bus.ld_busy  = 1'b1;
        bus.ld_ready = 1'b1;
      end
      DONE:    bus.ld_done = 1'b1;
      default: ;
    endcase
  end

  // Memory is never cleared; a loader word arriving on the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (load_accept && !reset) mem[ptr] <= bus.ld_data;
    else if (cpu_write)        mem[bus.adr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.ld_start) count <= '0;
      if (state == ARM) ptr <= '0;
      if (load_accept) begin
        ptr   <= ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        count <= count + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      if (err_set) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: loads, CPU access, stalls,
// memory-full termination, access errors and reset during a load.
module tb_mem_responder;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic idle);
    bus.cpu_idle = idle;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.rd_mem   = 1'b0;
    bus.wr_mem   = 1'b0;
    bus.adr      = '0;
    bus.data_in  = '0;
    bus.cpu_idle = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.hold, bus.ld_ready, bus.ld_busy, bus.ld_done, bus.err} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {bus.hold, bus.ld_ready, bus.ld_busy, bus.ld_done, bus.err});
    else passes++;
    checks++;
    if (bus.ld_count !== 7'd0)
      $display("[TB] FAIL reset_count: got %0d expected 0", bus.ld_count);
    else passes++;
  endtask

  task automatic test_load4();
    logic [7:0] words [4];
    int done_pulses;
    words[0] = 8'h05; words[1] = 8'h46; words[2] = 8'hC5; words[3] = 8'h80;
    done_pulses = 0;
    start_load(1'b1);
    checks++;
    if ({bus.ld_ready, bus.ld_busy, bus.hold} !== 3'b011)
      $display("[TB] FAIL load4_arm: got ready/busy/hold %b expected 011",
               {bus.ld_ready, bus.ld_busy, bus.hold});
    else passes++;
    tick();
    checks++;
    if (bus.ld_ready !== 1'b1)
      $display("[TB] FAIL load4_ready_latency: got %b expected 1", bus.ld_ready);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = (i == 3);
      tick();
      if (bus.ld_done === 1'b1) done_pulses++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    checks++;
    if ({bus.ld_done, bus.hold} !== 2'b10)
      $display("[TB] FAIL load4_done: got done/hold %b expected 10", {bus.ld_done, bus.hold});
    else passes++;
    checks++;
    if (bus.ld_count !== 7'd4)
      $display("[TB] FAIL load4_count: got %0d expected 4", bus.ld_count);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ld_done === 1'b1) done_pulses++;
    end
    checks++;
    if (done_pulses != 1)
      $display("[TB] FAIL load4_done_pulses: got %0d expected 1", done_pulses);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      bus.rd_mem = 1'b1;
      bus.adr    = 6'(i);
      #1;
      checks++;
      if (bus.data_out !== words[i])
        $display("[TB] FAIL load4_read%0d: got %h expected %h", i, bus.data_out, words[i]);
      else passes++;
    end
    bus.rd_mem = 1'b0;
  endtask

  task automatic test_cpu_write();
    bus.wr_mem  = 1'b1;
    bus.adr     = 6'h06;
    bus.data_in = 8'h2A;
    tick();
    bus.wr_mem = 1'b0;
    bus.rd_mem = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 8'h2A)
      $display("[TB] FAIL cpu_write_read: got %h expected 2a", bus.data_out);
    else passes++;
    tick();
    bus.rd_mem = 1'b0;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL cpu_write_err: got %b expected 0", bus.err);
    else passes++;
  endtask

  task automatic test_arm_wait();
    int bad;
    bad = 0;
    start_load(1'b0);
    bus.rd_mem = 1'b1;
    bus.adr    = 6'h06;
    for (int i = 0; i < 5; i++) begin
      #1;
      if ({bus.ld_busy, bus.hold, bus.ld_ready} !== 3'b110 || bus.data_out !== 8'h00) bad++;
      tick();
    end
    bus.rd_mem = 1'b0;
    checks++;
    if (bad != 0)
      $display("[TB] FAIL arm_wait_flags: got %0d bad cycles expected 0", bad);
    else passes++;
    checks++;
    if (bus.err !== 1'b0)
      $display("[TB] FAIL arm_access_err: got %b expected 0", bus.err);
    else passes++;
    bus.cpu_idle = 1'b1;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0)
      $display("[TB] FAIL arm_ready_early: got %b expected 0", bus.ld_ready);
    else passes++;
    tick();
    checks++;
    if (bus.ld_ready !== 1'b1)
      $display("[TB] FAIL arm_ready_after_idle: got %b expected 1", bus.ld_ready);
    else passes++;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h11;
    bus.ld_last  = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    checks++;
    if (bus.ld_count !== 7'd1)
      $display("[TB] FAIL arm_load_count: got %0d expected 1", bus.ld_count);
    else passes++;
    tick();
  endtask

  task automatic test_valid_gaps();
    logic [4:0] vpat;
    logic [7:0] exp_mem [4];
    vpat = 5'b11001;
    exp_mem[0] = 8'hA0; exp_mem[1] = 8'hA3; exp_mem[2] = 8'hA4; exp_mem[3] = 8'h80;
    start_load(1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = vpat[i];
      bus.ld_data  = 8'hA0 + 8'(i);
      bus.ld_last  = (i == 4);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    checks++;
    if ({bus.ld_done, bus.ld_count} !== {1'b1, 7'd3})
      $display("[TB] FAIL gaps_done_count: got done %b count %0d expected done 1 count 3",
               bus.ld_done, bus.ld_count);
    else passes++;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.rd_mem = 1'b1;
      bus.adr    = 6'(i);
      #1;
      checks++;
      if (bus.data_out !== exp_mem[i])
        $display("[TB] FAIL gaps_read%0d: got %h expected %h", i, bus.data_out, exp_mem[i]);
      else passes++;
    end
    bus.rd_mem = 1'b0;
  endtask

  task automatic test_full();
    int not_ready;
    int early_done;
    not_ready  = 0;
    early_done = 0;
    start_load(1'b1);
    tick();
    for (int i = 0; i < 64; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i * 3 + 1);
      bus.ld_last  = 1'b0;
      #1;
      if (bus.ld_ready !== 1'b1) not_ready++;
      if (bus.ld_done === 1'b1) early_done++;
      tick();
    end
    checks++;
    if (not_ready != 0 || early_done != 0)
      $display("[TB] FAIL full_stream: got %0d not-ready and %0d early-done cycles expected 0",
               not_ready, early_done);
    else passes++;
    bus.ld_data = 8'hFF;
    checks++;
    if ({bus.ld_done, bus.ld_ready, bus.ld_count} !== {1'b1, 1'b0, 7'd64})
      $display("[TB] FAIL full_done: got done %b ready %b count %0d expected 1 0 64",
               bus.ld_done, bus.ld_ready, bus.ld_count);
    else passes++;
    tick();
    checks++;
    if (bus.ld_ready !== 1'b0)
      $display("[TB] FAIL full_extra_ready: got %b expected 0", bus.ld_ready);
    else passes++;
    tick();
    bus.ld_valid = 1'b0;
    bus.rd_mem   = 1'b1;
    bus.adr      = 6'd0;
    #1;
    checks++;
    if (bus.data_out !== 8'h01)
      $display("[TB] FAIL full_mem0: got %h expected 01", bus.data_out);
    else passes++;
    bus.adr = 6'd63;
    #1;
    checks++;
    if (bus.data_out !== 8'hBE)
      $display("[TB] FAIL full_mem63: got %h expected be", bus.data_out);
    else passes++;
    bus.rd_mem = 1'b0;
  endtask

  task automatic test_errors();
    start_load(1'b1);
    tick();
    bus.rd_mem = 1'b1;
    bus.adr    = 6'd0;
    #1;
    checks++;
    if (bus.data_out !== 8'h00)
      $display("[TB] FAIL load_read_blocked: got %h expected 00", bus.data_out);
    else passes++;
    tick();
    bus.rd_mem = 1'b0;
    checks++;
    if (bus.err !== 1'b1)
      $display("[TB] FAIL load_access_err: got %b expected 1", bus.err);
    else passes++;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h3C;
    bus.ld_last  = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    tick();
    bus.rd_mem  = 1'b1;
    bus.wr_mem  = 1'b1;
    bus.adr     = 6'd5;
    bus.data_in = 8'h77;
    #1;
    checks++;
    if (bus.data_out !== 8'h00)
      $display("[TB] FAIL collide_data: got %h expected 00", bus.data_out);
    else passes++;
    tick();
    bus.wr_mem = 1'b0;
    #1;
    checks++;
    if ({bus.err, bus.data_out} !== {1'b1, 8'h77})
      $display("[TB] FAIL collide_err_write: got err %b data %h expected 1 77",
               bus.err, bus.data_out);
    else passes++;
    bus.rd_mem = 1'b0;
    start_load(1'b1);
    tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hD1;
    tick();
    bus.ld_data  = 8'hD2;
    tick();
    bus.ld_data  = 8'hD3;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    checks++;
    if ({bus.err, bus.ld_busy, bus.hold, bus.ld_done, bus.ld_count} !== 11'b0)
      $display("[TB] FAIL midload_reset: got err %b busy %b hold %b done %b count %0d expected all 0",
               bus.err, bus.ld_busy, bus.hold, bus.ld_done, bus.ld_count);
    else passes++;
    tick();
    checks++;
    if (bus.ld_done !== 1'b0)
      $display("[TB] FAIL midload_no_done: got %b expected 0", bus.ld_done);
    else passes++;
    bus.rd_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp_v;
      exp_v = (i == 0) ? 8'hD1 : (i == 1) ? 8'hD2 : 8'h07;
      bus.adr = 6'(i);
      #1;
      checks++;
      if (bus.data_out !== exp_v)
        $display("[TB] FAIL midload_retain%0d: got %h expected %h", i, bus.data_out, exp_v);
      else passes++;
    end
    bus.rd_mem = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_load4();
    test_cpu_write();
    test_arm_wait();
    test_valid_gaps();
    test_full();
    test_errors();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
